// File: rtl/data_memory_responder_if.sv
// MEM-stage data memory bus: request from the pipeline, busywait/readdata back from the responder.
interface data_memory_responder_if;
  logic        read;
  logic        write;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic        misaligned;

  modport master (
    output read, write, func3, address, writedata,
    input  readdata, busywait, misaligned
  );

  modport slave (
    input  read, write, func3, address, writedata,
    output readdata, busywait, misaligned
  );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responding to the MEM-stage busywait protocol,
// returning byte/halfword extended load data.
module data_memory_responder #(
  parameter int unsigned ADDR_WORDS = 256,
  parameter int unsigned LATENCY    = 4
) (
  input logic                    clk,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int unsigned AW   = $clog2(ADDR_WORDS);
  localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [2:0]        f3_q, f3_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              mis_q, mis_d;
  logic              busy;
  logic              access;

  logic [31:0]       mem_q [ADDR_WORDS];

  // High address bits are intentionally ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^bus.address[31:AW+2];

  // Access decode from the latched request.
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_byte, is_half, is_uns, mis;
  logic [31:0]   word, load_val, st_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    st_be;
  logic          mem_we;

  assign idx      = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign is_byte  = (f3_q[1:0] == 2'b00);
  assign is_half  = (f3_q[1:0] == 2'b01);
  assign is_uns   = f3_q[2];
  assign mis      = is_half ? lane[0] : (!is_byte && (lane != 2'b00));
  assign word     = mem_q[idx];
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    st_data  = wdata_q;
    st_be    = 4'b1111;
    if (is_byte) begin
      load_val = is_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      st_data  = {4{wdata_q[7:0]}};
      st_be    = 4'b0001 << lane;
    end else if (is_half) begin
      load_val = is_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      st_data  = {2{wdata_q[15:0]}};
      st_be    = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    mis_d      = 1'b0;
    busy       = 1'b0;
    access     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.read || bus.write) begin
          busy    = 1'b1;
          rd_d    = bus.read;
          wr_d    = bus.write;
          f3_d    = bus.func3;
          addr_d  = bus.address[AW+1:0];
          wdata_d = bus.writedata;
          cnt_d   = CntW'(LATENCY - 2);
          state_d = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          mis_d   = mis;
          state_d = StDone;
          // A simultaneous read+write is a store and leaves readdata alone.
          if (rd_q && !wr_q) readdata_d = mis ? 32'd0 : load_val;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      readdata_q <= 32'd0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      mis_q      <= mis_d;
    end
  end

  // Memory is not reset; a reset on the commit edge drops the pending store.
  assign mem_we = access && wr_q && !mis && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.busywait   = busy;
  assign bus.readdata   = readdata_q;
  assign bus.misaligned = mis_q;

endmodule
